// File: rtl/neo_video_pkg.sv
// rtl/neo_video_pkg.sv - shared NeoGeo raster timing, pixel type and sync polarity
// Contents: default timing localparams (*_DEF), derived totals, rgb888_t,
// sync polarity constants, and the colour-bar lookup used by the optional
// NEO_TIMING_TEST_PATTERN_EN source.
package neo_video_pkg;

    localparam int CE_DIV_DEF   = 16;
    localparam int H_ACTIVE_DEF = 320;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 32;
    localparam int H_BP_DEF     = 16;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_ACTIVE_DEF = 224;
    localparam int V_FP_DEF     = 8;
    localparam int V_SYNC_DEF   = 8;
    localparam int V_BP_DEF     = 24;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic HS_ACTIVE = 1'b0;
    localparam logic HS_IDLE   = 1'b1;
    localparam logic VS_ACTIVE = 1'b1;
    localparam logic VS_IDLE   = 1'b0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Eight 40-pixel bars. x[8:3] is x/8, so bar n starts where x[8:3] reaches 5*n;
    // counting thresholds crossed avoids a divider.
    // Bar order white..black maps onto idx bits: r=~idx[1], g=~idx[2], b=~idx[0].
    function automatic rgb888_t bar_colour(input logic [8:0] x);
        logic [5:0] xq;
        logic [2:0] idx;
        xq  = x[8:3];
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (xq >= 6'(5 * i)) begin
                idx = idx + 3'd1;
            end
        end
        bar_colour.r = {8{~idx[1]}};
        bar_colour.g = {8{~idx[2]}};
        bar_colour.b = {8{~idx[0]}};
    endfunction

endpackage

// File: rtl/neo_raster_counter.sv
// rtl/neo_raster_counter.sv - pixel clock-enable divider and h/v raster counters
// Ports: clk_in, reset (async, active high); ce (one clock in CE_DIV);
// h_cnt/v_cnt (current raster position); h_wrap/v_wrap (end-of-line/frame on ce).
module neo_raster_counter #(
    parameter int CE_DIV  = 16,
    parameter int H_TOTAL = 384,
    parameter int V_TOTAL = 264
) (
    input  logic       clk_in,
    input  logic       reset,
    output logic       ce,
    output logic [8:0] h_cnt,
    output logic [8:0] v_cnt,
    output logic       h_wrap,
    output logic       v_wrap
);

    localparam int CW = $clog2(CE_DIV);

    logic [CW-1:0] ce_cnt;

    assign ce     = (ce_cnt == CW'(CE_DIV - 1));
    assign h_wrap = ce && (h_cnt == 9'(H_TOTAL - 1));
    assign v_wrap = h_wrap && (v_cnt == 9'(V_TOTAL - 1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ce_cnt <= '0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            ce_cnt <= ce ? '0 : ce_cnt + CW'(1);
            if (ce) begin
                h_cnt <= h_wrap ? 9'd0 : h_cnt + 9'd1;
                if (h_wrap) begin
                    v_cnt <= v_wrap ? 9'd0 : v_cnt + 9'd1;
                end
            end
        end
    end

endmodule

// File: rtl/neo_video_timing_gen.sv
// rtl/neo_video_timing_gen.sv - NeoGeo raster source: pixel fetch plus registered RGB/hs/vs/de
// Ports: clk_in, reset (async, active high); pix_req/pix_x/pix_y fetch request,
// pix_data {r,g,b} reply; test_pattern (only with NEO_TIMING_TEST_PATTERN_EN);
// out_r/out_g/out_b, out_hs (active low), out_vs (active high), out_de (one-clock
// strobe per pixel), frame_start (one clock on vsync assertion).
module neo_video_timing_gen
    import neo_video_pkg::*;
#(
    parameter int CE_DIV   = CE_DIV_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clk_in,
    input  logic        reset,
    output logic        pix_req,
    output logic [8:0]  pix_x,
    output logic [7:0]  pix_y,
    input  logic [23:0] pix_data,
    input  logic        test_pattern,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_de,
    output logic        frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic       ce;
    logic [8:0] h_cnt;
    logic [8:0] v_cnt;
    logic       h_wrap_unused;
    logic       v_wrap_unused;

    neo_raster_counter #(
        .CE_DIV (CE_DIV),
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_raster (
        .clk_in(clk_in),
        .reset (reset),
        .ce    (ce),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .h_wrap(h_wrap_unused),
        .v_wrap(v_wrap_unused)
    );

    logic active;
    logic hs_on;
    logic vs_on;

    assign active = (h_cnt < 9'(H_ACTIVE)) && (v_cnt < 9'(V_ACTIVE));
    assign hs_on  = (h_cnt >= 9'(HS_START)) && (h_cnt < 9'(HS_END));
    assign vs_on  = (v_cnt >= 9'(VS_START)) && (v_cnt < 9'(VS_END));

    logic    use_tp;
    rgb888_t src_rgb;

`ifdef NEO_TIMING_TEST_PATTERN_EN
    // Bar colour rides through the fetch stage so it lines up with the sync delay.
    logic    tp_valid;
    rgb888_t tp_rgb;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            tp_valid <= 1'b0;
            tp_rgb   <= '0;
        end else if (ce) begin
            tp_valid <= test_pattern;
            tp_rgb   <= bar_colour(h_cnt);
        end
    end

    assign use_tp  = test_pattern;
    assign src_rgb = tp_valid ? tp_rgb : rgb888_t'(pix_data);
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;
    assign use_tp  = 1'b0;
    assign src_rgb = rgb888_t'(pix_data);
`endif

    logic    fetch_valid;
    logic    fetch_hs;
    logic    fetch_vs;
    rgb888_t out_rgb;

    // Fetch stage issues the request and registers what the output stage needs;
    // the output stage captures pix_data a full pixel later, giving the source
    // CE_DIV-1 clocks to answer while keeping rgb/hs/vs/de on one uniform delay.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            fetch_valid <= 1'b0;
            fetch_hs    <= HS_IDLE;
            fetch_vs    <= VS_IDLE;
            out_rgb     <= '0;
            out_hs      <= HS_IDLE;
            out_vs      <= VS_IDLE;
            out_de      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_req     <= 1'b0;
            out_de      <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                fetch_valid <= active;
                fetch_hs    <= hs_on ? HS_ACTIVE : HS_IDLE;
                fetch_vs    <= vs_on ? VS_ACTIVE : VS_IDLE;
                if (active && !use_tp) begin
                    pix_req <= 1'b1;
                    pix_x   <= h_cnt;
                    pix_y   <= v_cnt[7:0];
                end
                out_rgb     <= fetch_valid ? src_rgb : '0;
                out_de      <= fetch_valid;
                out_hs      <= fetch_hs;
                out_vs      <= fetch_vs;
                frame_start <= (fetch_vs == VS_ACTIVE) && (out_vs == VS_IDLE);
            end
        end
    end

    assign out_r = out_rgb.r;
    assign out_g = out_rgb.g;
    assign out_b = out_rgb.b;

endmodule

// File: tb/tb_neo_video_timing_gen.sv
// tb/tb_neo_video_timing_gen.sv - scoreboard bench for neo_video_timing_gen on a reduced raster
module tb_neo_video_timing_gen;

    localparam int CE  = 8;
    localparam int HA  = 48;
    localparam int HF  = 2;
    localparam int HSW = 4;
    localparam int HB  = 2;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VA  = 6;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 1;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FR  = HT * VT;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        pix_req;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [23:0] pix_data = 24'h0;
    logic        test_pattern = 1'b0;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_hs, out_vs, out_de, frame_start;

    always #5 clk_in = ~clk_in;

    neo_video_timing_gen #(
        .CE_DIV(CE), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .clk_in(clk_in), .reset(reset), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .test_pattern(test_pattern), .out_r(out_r), .out_g(out_g),
        .out_b(out_b), .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
        .frame_start(frame_start)
    );

    int vectors     = 0;
    int miscompares = 0;
    int edge_no;
    bit chk_en  = 1'b0;
    bit tp_mode = 1'b0;

    // Clock edges since reset release; edge 1 is the first edge with reset low.
    always @(posedge clk_in or posedge reset) begin
        if (reset) edge_no <= 0;
        else       edge_no <= edge_no + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int x);
        logic [23:0] tbl [8];
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return tbl[x / 40];
    endfunction

    function automatic logic [23:0] pix_value(input int h, input int v, input bit tp);
        return tp ? bar_rgb(h) : {8'(h), 8'(v), 8'hA5};
    endfunction

    typedef struct {
        bit          req;
        int          px;
        int          py;
        bit          hs;
        bit          vs;
        logic [23:0] rgb;
    } exp_t;

    // Raster position n is fetched on ce edge CE*(n+1) and shown on CE*(n+2).
    function automatic exp_t model_at(input int e, input bit tp);
        exp_t x;
        int m, k, p, h, v;
        m = e / CE;
        x.req = 1'b0; x.px = 0; x.py = 0; x.hs = 1'b1; x.vs = 1'b0; x.rgb = 24'h0;
        if (m >= 1 && !tp) begin
            k = m - 1;
            p = k % FR; h = p % HT; v = p / HT;
            x.req = (e % CE == 0) && h < HA && v < VA;
            if (v < VA) begin
                x.px = (h < HA) ? h : HA - 1;
                x.py = v;
            end else begin
                x.px = HA - 1;
                x.py = VA - 1;
            end
        end
        if (m >= 2) begin
            p = (m - 2) % FR; h = p % HT; v = p / HT;
            x.hs  = !(h >= HA + HF && h < HA + HF + HSW);
            x.vs  = (v >= VA + VF && v < VA + VF + VSW);
            x.rgb = (h < HA && v < VA) ? pix_value(h, v, tp) : 24'h0;
        end
        return x;
    endfunction

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
    } ev_t;

    ev_t de_q[$];
    int  fs_q[$];

    task automatic build_expect(input bit tp, input int horizon);
        ev_t ev;
        int  p, h, v;
        de_q.delete();
        fs_q.delete();
        for (int n = 0; CE * (n + 2) <= horizon; n++) begin
            p = n % FR; h = p % HT; v = p / HT;
            if (h < HA && v < VA) begin
                ev.cyc = CE * (n + 2);
                ev.rgb = pix_value(h, v, tp);
                de_q.push_back(ev);
            end
            if (p == (VA + VF) * HT) fs_q.push_back(CE * (n + 2));
        end
    endtask

    // Pixel source: random latency within the allowed window, garbage until then.
    int       src_dly;
    bit       src_pend;
    logic [8:0] src_x;
    logic [7:0] src_y;
    always @(negedge clk_in) begin
        if (reset) begin
            src_pend = 1'b0;
        end else if (pix_req) begin
            src_pend = 1'b1;
            src_dly  = $urandom_range(1, CE - 1);
            src_x    = pix_x;
            src_y    = pix_y;
            pix_data = 24'($urandom);
        end else if (src_pend) begin
            src_dly--;
            if (src_dly == 0) begin
                pix_data = {src_x[7:0], src_y, 8'hA5};
                src_pend = 1'b0;
            end
        end
    end

    bit prev_hs, prev_vs, prev_de, have_hfall, have_vrise, have_fs;
    int hfall_edge, vrise_edge, fs_edge, line_idx, line_de, frame_de;

    task automatic clear_trackers();
        prev_hs = 1'b1; prev_vs = 1'b0; prev_de = 1'b0;
        have_hfall = 1'b0; have_vrise = 1'b0; have_fs = 1'b0;
        line_idx = 0; line_de = 0; frame_de = 0;
    endtask

    task automatic monitor_step();
        exp_t        x;
        logic [23:0] act;
        act = {out_r, out_g, out_b};
        x   = model_at(edge_no, tp_mode);
        check("pix_req", pix_req, x.req);
        check("pix_x", pix_x, x.px);
        check("pix_y", pix_y, x.py);
        check("out_hs", out_hs, x.hs);
        check("out_vs", out_vs, x.vs);
        check("out_rgb", act, x.rgb);
        if (!tp_mode && edge_no == CE * (FR + 1)) begin
            check("wrap_req", {pix_req, 7'd0, pix_x, pix_y}, 32'h0100_0000);
        end

        if (de_q.size() > 0 && de_q[0].cyc == edge_no) begin
            check("de_strobe", out_de, 1);
            check("de_rgb", act, de_q[0].rgb);
            void'(de_q.pop_front());
        end else if (out_de) begin
            check("de_strobe", out_de, 0);
        end
        if (out_de) check("de_width", prev_de, 0);

        if (fs_q.size() > 0 && fs_q[0] == edge_no) begin
            check("frame_start", frame_start, 1);
            void'(fs_q.pop_front());
        end else if (frame_start) begin
            check("frame_start", frame_start, 0);
        end

        if (out_de) begin
            line_de++;
            frame_de++;
        end
        if (prev_hs && !out_hs) begin
            check("line_de_count", line_de, ((line_idx % VT) < VA) ? HA : 0);
            line_idx++;
            line_de    = 0;
            hfall_edge = edge_no;
            have_hfall = 1'b1;
        end
        if (!prev_hs && out_hs && have_hfall) check("hs_low_clocks", edge_no - hfall_edge, HSW * CE);
        if (!prev_vs && out_vs) begin
            vrise_edge = edge_no;
            have_vrise = 1'b1;
        end
        if (prev_vs && !out_vs && have_vrise) check("vs_high_clocks", edge_no - vrise_edge, VSW * HT * CE);
        if (frame_start) begin
            check("frame_de_count", frame_de, HA * VA);
            if (have_fs) check("frame_gap", edge_no - fs_edge, FR * CE);
            else         check("fs_after_release", edge_no, CE * ((VA + VF) * HT + 2));
            frame_de = 0;
            fs_edge  = edge_no;
            have_fs  = 1'b1;
        end
        prev_hs = out_hs;
        prev_vs = out_vs;
        prev_de = out_de;
    endtask

    always @(negedge clk_in) begin
        if (reset)       clear_trackers();
        else if (chk_en) monitor_step();
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_pix_req"}, pix_req, 0);
        check({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
        check({tag, "_rgb"}, {out_r, out_g, out_b}, 0);
        check({tag, "_hs"}, out_hs, 1);
        check({tag, "_vs"}, out_vs, 0);
        check({tag, "_de"}, out_de, 0);
        check({tag, "_frame_start"}, frame_start, 0);
    endtask

    task automatic release_reset(input bit tp, input int horizon);
        @(negedge clk_in);
        #2;
        tp_mode = tp;
        build_expect(tp, horizon);
        reset  = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        int n_target, target_e, h0;
        repeat (3) @(negedge clk_in);
        #1;
        check_reset_values("reset");

        release_reset(1'b0, 4 * FR * CE);
        repeat (2 * FR * CE + 100) @(negedge clk_in);

        // Mid-line reset while a de strobe is high.
        h0       = $urandom_range(1, HA - 2);
        n_target = ((edge_no / CE) / FR + 1) * FR + (VA / 2) * HT + h0;
        target_e = CE * (n_target + 2);
        for (int i = 0; i < 3 * FR * CE && edge_no != target_e; i++) @(negedge clk_in);
        check("reach_target", edge_no, target_e);
        check("de_before_reset", out_de, 1);
        #2;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_reset_values("async_reset");
        repeat (3) @(negedge clk_in);
        release_reset(1'b0, 2 * FR * CE);
        repeat (FR * CE + 200) @(negedge clk_in);

`ifdef NEO_TIMING_TEST_PATTERN_EN
        #2;
        chk_en       = 1'b0;
        reset        = 1'b1;
        test_pattern = 1'b1;
        repeat (2) @(negedge clk_in);
        release_reset(1'b1, 2 * FR * CE);
        repeat (FR * CE + 200) @(negedge clk_in);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
